// File: rtl/event_merge_if.sv
// Bundle between the event merger and its surroundings: board FIFO heads/pops in, merged stream out.
// No logic of its own; widths follow the merger's parameters.
// Backpressure is carried by board_empty (per board) and merged_almost_full (downstream).
interface event_merge_if #(
  parameter int DATA_WIDTH         = 65,
  parameter int TOTAL_INPUT_BOARDS = 4
);
  logic [TOTAL_INPUT_BOARDS-1:0][DATA_WIDTH-1:0] board_data;
  logic [TOTAL_INPUT_BOARDS-1:0]                 board_req;
  logic [TOTAL_INPUT_BOARDS-1:0]                 board_empty;
  logic [DATA_WIDTH-1:0]                         merged_event;
  logic                                          merged_wren;
  logic                                          merged_almost_full;
  logic [TOTAL_INPUT_BOARDS-1:0]                 l0id_mismatch;
  logic                                          framing_err;
  logic [31:0]                                   event_count;

  // The merger side.
  modport master (
    input  board_data, board_empty, merged_almost_full,
    output board_req, merged_event, merged_wren, l0id_mismatch, framing_err, event_count
  );

  // The environment side: board FIFOs, downstream FIFO, status consumer.
  modport slave (
    output board_data, board_empty, merged_almost_full,
    input  board_req, merged_event, merged_wren, l0id_mismatch, framing_err, event_count
  );
endinterface

// File: rtl/event_merge.sv
// Merges one fragment per board (board 0 first) into a single event, checking L0IDs against board 0.
// Latency: a word popped in cycle t is written downstream in cycle t+1; 1 word/cycle throughput.
// Backpressure: merged_almost_full or an empty current board stalls pops in the same cycle.
module event_merge #(
  parameter int DATA_WIDTH         = 65,
  parameter int TOTAL_INPUT_BOARDS = 4,
  parameter int L0ID_BITS          = 32
) (
  input logic          es_clk,
  input logic          es_rst_n,
  input logic          es_srst_n,
  event_merge_if.master bus
);

  localparam int IDX_W = $clog2(TOTAL_INPUT_BOARDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_INPUT_BOARDS - 1);
  localparam logic [7:0] TAG_HDR = 8'hAB;
  localparam logic [7:0] TAG_FTR = 8'hCD;

  typedef enum logic {
    WAIT_HDR = 1'b0,
    BODY     = 1'b1
  } state_t;

  state_t                        state;
  state_t                        state_nxt;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              idx_nxt;
  logic [L0ID_BITS-1:0]          l0id;
  logic [DATA_WIDTH-1:0]         head;
  logic                          run;
  logic                          pop;
  logic                          is_hdr;
  logic                          is_ftr;
  logic                          fwd;
  logic                          latch_l0id;
  logic                          ferr_set;
  logic                          cnt_inc;
  logic [TOTAL_INPUT_BOARDS-1:0] mm_set;

  // Either reset holds the pop strobes low so nothing is consumed while the FSM is being cleared.
  assign run    = es_rst_n & es_srst_n;
  assign head   = bus.board_data[idx];
  assign pop    = run & ~bus.board_empty[idx] & ~bus.merged_almost_full;
  assign is_hdr = head[DATA_WIDTH-1] & (head[63:56] == TAG_HDR);
  assign is_ftr = head[DATA_WIDTH-1] & (head[63:56] == TAG_FTR);

  // Pop strobe goes only to the board currently being merged.
  always_comb begin
    bus.board_req = '0;
    if (pop) bus.board_req[idx] = 1'b1;
  end

  // Next-state, next-index and per-word actions for the popped head word.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    fwd        = 1'b0;
    latch_l0id = 1'b0;
    ferr_set   = 1'b0;
    cnt_inc    = 1'b0;
    mm_set     = '0;
    if (pop) begin
      case (state)
        WAIT_HDR: begin
          if (is_hdr) begin
            state_nxt = BODY;
            if (idx == '0) begin
              fwd        = 1'b1;
              latch_l0id = 1'b1;
            end else if (head[L0ID_BITS-1:0] != l0id) begin
              mm_set[idx] = 1'b1;
            end
          end else begin
            // Junk ahead of a header is discarded; keep hunting for the header.
            ferr_set = 1'b1;
          end
        end
        BODY: begin
          if (is_ftr) begin
            state_nxt = WAIT_HDR;
            if (idx == LAST_IDX) begin
              fwd     = 1'b1;
              cnt_inc = 1'b1;
              idx_nxt = '0;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end else if (is_hdr) begin
            // A header inside a fragment means the footer went missing; drop it and stay put.
            ferr_set = 1'b1;
          end else begin
            fwd = 1'b1;
          end
        end
        default: state_nxt = WAIT_HDR;
      endcase
    end
  end

  // FSM state and board index.
  always_ff @(posedge es_clk or negedge es_rst_n) begin
    if (!es_rst_n) begin
      state <= WAIT_HDR;
      idx   <= '0;
    end else if (!es_srst_n) begin
      state <= WAIT_HDR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Registered write port toward the downstream FIFO.
  always_ff @(posedge es_clk or negedge es_rst_n) begin
    if (!es_rst_n) begin
      bus.merged_event <= '0;
      bus.merged_wren  <= 1'b0;
    end else if (!es_srst_n) begin
      bus.merged_event <= '0;
      bus.merged_wren  <= 1'b0;
    end else begin
      bus.merged_wren <= fwd;
      if (fwd) bus.merged_event <= head;
    end
  end

  // Reference L0ID, sticky error flags and the completed-event counter.
  always_ff @(posedge es_clk or negedge es_rst_n) begin
    if (!es_rst_n) begin
      l0id              <= '0;
      bus.l0id_mismatch <= '0;
      bus.framing_err   <= 1'b0;
      bus.event_count   <= '0;
    end else if (!es_srst_n) begin
      l0id              <= '0;
      bus.l0id_mismatch <= '0;
      bus.framing_err   <= 1'b0;
      bus.event_count   <= '0;
    end else begin
      if (latch_l0id) l0id <= head[L0ID_BITS-1:0];
      bus.l0id_mismatch <= bus.l0id_mismatch | mm_set;
      if (ferr_set) bus.framing_err <= 1'b1;
      if (cnt_inc) bus.event_count <= bus.event_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_event_merge.sv
// Bench for event_merge: queue-backed board FIFOs, a fragment-level expected-stream model,
// a table of directed events, hand sequences for stall/backpressure/reset, and a random run.
module tb_event_merge;
  localparam int DW = 65;
  localparam int NB = 4;
  localparam int DEPTH = 1024;

  logic es_clk = 1'b0;
  logic es_rst_n = 1'b0;
  logic es_srst_n = 1'b1;
  logic af = 1'b0;
  logic [NB-1:0] starve = '0;

  event_merge_if #(.DATA_WIDTH(DW), .TOTAL_INPUT_BOARDS(NB)) bus ();

  event_merge #(.DATA_WIDTH(DW), .TOTAL_INPUT_BOARDS(NB), .L0ID_BITS(32)) dut (
    .es_clk   (es_clk),
    .es_rst_n (es_rst_n),
    .es_srst_n(es_srst_n),
    .bus      (bus)
  );

  always #5 es_clk = ~es_clk;

  // Board FIFO model: storage written by the stimulus, read pointer advanced on board_req.
  logic [DW-1:0] mem [NB][DEPTH];
  int wr_p[NB];
  int rd_p[NB];

  for (genvar g = 0; g < NB; g++) begin : g_board
    assign bus.board_data[g]  = mem[g][rd_p[g]];
    assign bus.board_empty[g] = (rd_p[g] == wr_p[g]) || starve[g];
  end
  assign bus.merged_almost_full = af;

  always @(posedge es_clk) begin
    for (int b = 0; b < NB; b++)
      if (bus.board_req[b]) rd_p[b] <= rd_p[b] + 1;
  end

  // Downstream FIFO capture and pop-protocol monitor.
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] exp_q[$];
  int viol = 0;

  always @(posedge es_clk) begin
    if (bus.merged_wren) out_q.push_back(bus.merged_event);
    if ($countones(bus.board_req) > 1) viol++;
    if ((bus.board_req & bus.board_empty) != '0) viol++;
    if (af && (bus.board_req != '0)) viol++;
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [NB-1:0] exp_mm;
  logic exp_ferr;
  logic [31:0] exp_cnt;
  int seq = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic logic [DW-1:0] hdr_w(input logic [31:0] id);
    return {1'b1, 8'hAB, 24'h0, id};
  endfunction

  function automatic logic [DW-1:0] ftr_w(input int b);
    return {1'b1, 8'hCD, 48'h0, 8'(b)};
  endfunction

  task automatic push(input int b, input logic [DW-1:0] w);
    mem[b][wr_p[b]] = w;
    wr_p[b]++;
  endtask

  // Pushes one fragment per selected board and appends what the merged stream must contain:
  // board 0 header, every payload in board order, last board's footer.
  task automatic load_event(input logic [NB-1:0][31:0] l0, input logic [NB-1:0][3:0] np,
                            input bit junk0, input bit dup1, input bit rnd, input logic [NB-1:0] mask);
    logic [DW-1:0] w;
    logic [55:0] r;
    logic [7:0] tag;
    logic meta;
    for (int b = 0; b < NB; b++) begin
      if (mask[b]) begin
        if (b == 0 && junk0) begin
          push(0, 65'h1234);
          exp_ferr = 1'b1;
        end
        push(b, hdr_w(l0[b]));
        if (b == 0) exp_q.push_back(hdr_w(l0[0]));
        else if (l0[b] != l0[0]) exp_mm[b] = 1'b1;
        if (b == 1 && dup1) begin
          push(1, hdr_w(l0[1]));
          exp_ferr = 1'b1;
        end
        for (int i = 0; i < int'(np[b]); i++) begin
          if (rnd) begin
            r = 56'({$urandom(), $urandom()});
            tag = 8'($urandom());
            meta = 1'($urandom_range(0, 1));
            if (meta && (tag == 8'hAB || tag == 8'hCD)) tag = 8'h5A;
            w = {meta, tag, r};
          end else begin
            w = {1'b0, 8'h00, 8'(b), 16'(seq), 32'(i)};
          end
          push(b, w);
          exp_q.push_back(w);
        end
        push(b, ftr_w(b));
        if (b == NB - 1) exp_q.push_back(ftr_w(b));
      end
    end
    seq++;
    exp_cnt++;
  endtask

  function automatic int remaining();
    int s = 0;
    for (int b = 0; b < NB; b++) s += wr_p[b] - rd_p[b];
    return s;
  endfunction

  task automatic drain(input string name, input int budget, input bit rnd);
    int n = 0;
    forever begin
      @(negedge es_clk);
      if (remaining() == 0) break;
      if (n >= budget) begin
        chk({name, "_timeout"}, 65'(remaining()), 65'd0);
        break;
      end
      if (rnd) begin
        af = ($urandom_range(0, 3) == 0);
        for (int b = 0; b < NB; b++) starve[b] = ($urandom_range(0, 3) == 0);
      end
      n++;
    end
    af = 1'b0;
    starve = '0;
    repeat (3) @(negedge es_clk);
  endtask

  task automatic cmp_stream(input string name);
    int n;
    chk({name, "_len"}, 65'(out_q.size()), 65'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", name, i), out_q[i], exp_q[i]);
  endtask

  task automatic clear_model();
    out_q.delete();
    exp_q.delete();
    exp_mm = '0;
    exp_ferr = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic do_srst();
    @(negedge es_clk);
    es_srst_n = 1'b0;
    @(negedge es_clk);
    es_srst_n = 1'b1;
    clear_model();
  endtask

  typedef struct packed {
    logic [NB-1:0][31:0] l0id;
    logic [NB-1:0][3:0]  npay;
    logic                junk0;
    logic                dup1;
    logic [NB-1:0]       exp_mm;
    logic                exp_ferr;
    logic [31:0]         exp_words;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [NB-1:0][31:0] l0;
    logic [NB-1:0][3:0] np;
    logic [31:0] base;
    int s0, r2, r3, cyc, b1base;

    // Directed events: inputs plus hand-derived flags and merged length.
    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < NB; b++) begin
        vecs[r].l0id[b] = 32'd5;
        vecs[r].npay[b] = 4'd2;
      end
      vecs[r].junk0 = 1'b0;
      vecs[r].dup1 = 1'b0;
      vecs[r].exp_mm = '0;
      vecs[r].exp_ferr = 1'b0;
      vecs[r].exp_words = 32'd10;
    end
    vecs[1].l0id[2] = 32'd6;
    vecs[1].exp_mm = 4'b0100;
    for (int b = 0; b < NB; b++) vecs[2].npay[b] = 4'd1;
    vecs[2].junk0 = 1'b1;
    vecs[2].exp_ferr = 1'b1;
    vecs[2].exp_words = 32'd6;
    vecs[3].npay[0] = 4'd0; vecs[3].npay[1] = 4'd3; vecs[3].npay[2] = 4'd1; vecs[3].npay[3] = 4'd0;
    vecs[3].l0id[1] = 32'd7; vecs[3].l0id[3] = 32'd9;
    vecs[3].dup1 = 1'b1;
    vecs[3].exp_mm = 4'b1010;
    vecs[3].exp_ferr = 1'b1;
    vecs[3].exp_words = 32'd6;
    for (int b = 0; b < NB; b++) begin
      vecs[4].l0id[b] = 32'd3;
      vecs[4].npay[b] = (b == 0) ? 4'd5 : 4'd0;
    end
    vecs[4].exp_words = 32'd7;

    clear_model();

    // Reset state, with a non-empty board 0 to show pops are held off.
    push(0, hdr_w(32'd1));
    #12;
    chk("rst_req", 65'(bus.board_req), 65'd0);
    chk("rst_wren", 65'(bus.merged_wren), 65'd0);
    chk("rst_event", bus.merged_event, 65'd0);
    chk("rst_mm", 65'(bus.l0id_mismatch), 65'd0);
    chk("rst_ferr", 65'(bus.framing_err), 65'd0);
    chk("rst_cnt", 65'(bus.event_count), 65'd0);
    @(negedge es_clk);
    es_rst_n = 1'b1;

    for (int r = 0; r < 5; r++) begin
      do_srst();
      load_event(vecs[r].l0id, vecs[r].npay, vecs[r].junk0, vecs[r].dup1, 1'b0, '1);
      drain($sformatf("row%0d", r), 500, 1'b0);
      chk($sformatf("row%0d_words", r), 65'(out_q.size()), 65'(vecs[r].exp_words));
      cmp_stream($sformatf("row%0d", r));
      chk($sformatf("row%0d_mm", r), 65'(bus.l0id_mismatch), 65'(vecs[r].exp_mm));
      chk($sformatf("row%0d_ferr", r), 65'(bus.framing_err), 65'(vecs[r].exp_ferr));
      chk($sformatf("row%0d_cnt", r), 65'(bus.event_count), 65'd1);
    end

    // Backpressure held for 5 cycles mid-event.
    do_srst();
    for (int b = 0; b < NB; b++) begin l0[b] = 32'd5; np[b] = 4'd2; end
    load_event(l0, np, 1'b0, 1'b0, 1'b0, '1);
    cyc = 0;
    while (out_q.size() < 3 && cyc < 100) begin @(negedge es_clk); cyc++; end
    chk("bp_reach_body", 65'(out_q.size() >= 3), 65'd1);
    af = 1'b1;
    s0 = out_q.size();
    repeat (5) begin
      #1 chk("bp_no_req", 65'(bus.board_req), 65'd0);
      @(negedge es_clk);
    end
    chk("bp_trailing", 65'(out_q.size() - s0 <= 1), 65'd1);
    af = 1'b0;
    drain("bp", 500, 1'b0);
    cmp_stream("bp");
    chk("bp_cnt", 65'(bus.event_count), 65'd1);

    // Board 1 starved for 20 cycles after board 0's footer.
    do_srst();
    starve = 4'b0010;
    load_event(l0, np, 1'b0, 1'b0, 1'b0, '1);
    cyc = 0;
    while (rd_p[0] != wr_p[0] && cyc < 100) begin @(negedge es_clk); cyc++; end
    chk("starve_b0_done", 65'(wr_p[0] - rd_p[0]), 65'd0);
    r2 = rd_p[2];
    r3 = rd_p[3];
    s0 = 0;
    repeat (20) begin
      @(negedge es_clk);
      if (bus.board_req != '0) s0++;
    end
    chk("starve_no_req", 65'(s0), 65'd0);
    chk("starve_b2_untouched", 65'(rd_p[2]), 65'(r2));
    chk("starve_b3_untouched", 65'(rd_p[3]), 65'(r3));
    starve = '0;
    drain("starve", 500, 1'b0);
    cmp_stream("starve");
    chk("starve_cnt", 65'(bus.event_count), 65'd1);

    // Soft reset while board 1 is mid-fragment; its leftovers stay queued.
    for (int b = 0; b < NB; b++) l0[b] = 32'd7;
    np[0] = 4'd2; np[1] = 4'd4; np[2] = 4'd0; np[3] = 4'd0;
    b1base = wr_p[1];
    load_event(l0, np, 1'b0, 1'b0, 1'b0, 4'b0011);
    cyc = 0;
    while (rd_p[1] - b1base < 2 && cyc < 100) begin @(negedge es_clk); cyc++; end
    chk("srst_reach_b1", 65'(rd_p[1] - b1base), 65'd2);
    es_srst_n = 1'b0;
    #1 chk("srst_req", 65'(bus.board_req), 65'd0);
    @(posedge es_clk);
    #1;
    chk("srst_wren", 65'(bus.merged_wren), 65'd0);
    chk("srst_event", bus.merged_event, 65'd0);
    chk("srst_mm", 65'(bus.l0id_mismatch), 65'd0);
    chk("srst_ferr", 65'(bus.framing_err), 65'd0);
    chk("srst_cnt", 65'(bus.event_count), 65'd0);
    @(negedge es_clk);
    es_srst_n = 1'b1;
    clear_model();
    s0 = 0;
    repeat (3) begin
      #1 if (bus.board_req != '0) s0++;
      @(negedge es_clk);
    end
    chk("srst_idle_req", 65'(s0), 65'd0);
    for (int b = 0; b < NB; b++) begin l0[b] = 32'd8; np[b] = 4'd1; end
    load_event(l0, np, 1'b0, 1'b0, 1'b0, '1);
    drain("srst", 500, 1'b0);
    cmp_stream("srst");
    chk("srst_after_ferr", 65'(bus.framing_err), 65'd1);
    chk("srst_after_mm", 65'(bus.l0id_mismatch), 65'd0);
    chk("srst_after_cnt", 65'(bus.event_count), 65'd1);

    // Random events under random backpressure and starvation.
    do_srst();
    for (int e = 0; e < 30; e++) begin
      base = $urandom();
      for (int b = 0; b < NB; b++) begin
        l0[b] = (b > 0 && $urandom_range(0, 7) == 0) ? (base ^ 32'h1) : base;
        np[b] = 4'($urandom_range(0, 4));
      end
      load_event(l0, np, 1'b0, 1'b0, 1'b1, '1);
    end
    drain("rnd", 20000, 1'b1);
    cmp_stream("rnd");
    chk("rnd_mm", 65'(bus.l0id_mismatch), 65'(exp_mm));
    chk("rnd_ferr", 65'(bus.framing_err), 65'(exp_ferr));
    chk("rnd_cnt", 65'(bus.event_count), 65'(exp_cnt));

    chk("protocol_violations", 65'(viol), 65'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
